// File: rtl/temp_conv_pipe_if.sv
// Request/response stream bundle for temp_conv_pipe: valid/ready request in,
// valid/ready result out.
interface temp_conv_pipe_if #(
   parameter int TEMP_W = 8,
   parameter int CH_W   = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [CH_W-1:0]   in_ch;
   logic              unit;
   logic [TEMP_W-1:0] temperature;
   logic              out_valid;
   logic              out_ready;
   logic [CH_W-1:0]   out_ch;
   logic              out_unit;
   logic [TEMP_W-1:0] data;
   logic              oor;

   modport master (
      output in_valid, in_ch, unit, temperature, out_ready,
      input  in_ready, out_valid, out_ch, out_unit, data, oor
   );

   modport slave (
      input  in_valid, in_ch, unit, temperature, out_ready,
      output in_ready, out_valid, out_ch, out_unit, data, oor
   );
endinterface

// File: rtl/temp_conv_pipe.sv
// Multi-channel pipelined C<->F converter: two elaboration-time ROMs with
// saturation/oor, stall-on-backpressure, per-channel last-result registers.

module temp_conv_lane #(
   parameter int TEMP_W = 8
) (
   input  logic              gclk_i,
   input  logic              grst_n_i,
   input  logic              en_i,
   input  logic [TEMP_W-1:0] d_i,
   output logic [TEMP_W-1:0] q_o
);
   logic [TEMP_W-1:0] last_q;

   always_ff @(posedge gclk_i or negedge grst_n_i) begin
      if (!grst_n_i)  last_q <= '0;
      else if (en_i)  last_q <= d_i;
   end

   assign q_o = last_q;
endmodule

module temp_conv_pipe #(
   parameter int  TEMP_W = 8,
   parameter int  CH     = 4,
   parameter int  C_MAX  = 100,
   parameter int  F_MAX  = 212,
   localparam int CH_W   = $clog2(CH)
) (
   input  logic                       gclk_i,
   input  logic                       grst_n_i,
   temp_conv_pipe_if.slave            bus,
   output logic [CH-1:0][TEMP_W-1:0]  last_data_o
);
   localparam int DEPTH = 2**TEMP_W;

   // ROM words are {oor, value}
   function automatic logic [TEMP_W:0] cf_word(input int c);
      if (c <= C_MAX) return {1'b0, TEMP_W'((18*c + 5) / 10 + 32)};
      else            return {1'b1, TEMP_W'(F_MAX)};
   endfunction

   function automatic logic [TEMP_W:0] fc_word(input int f);
      if (f < 32)          return {1'b1, TEMP_W'(0)};
      else if (f > F_MAX)  return {1'b1, TEMP_W'(C_MAX)};
      else                 return {1'b0, TEMP_W'((10*(f - 32) + 9) / 18)};
   endfunction

   logic [TEMP_W:0] cf_rom [DEPTH];
   logic [TEMP_W:0] fc_rom [DEPTH];

   for (genvar a = 0; a < DEPTH; a++) begin : g_rom
      assign cf_rom[a] = cf_word(a);
      assign fc_rom[a] = fc_word(a);
   end

   // [0]: address stage, [1]: ROM read stage, [2]: output register
   logic [2:0]                 vld_pipe_q;
   logic [1:0][CH_W-1:0]       ch_pipe_q;
   logic [1:0]                 unit_pipe_q;
   logic [TEMP_W-1:0]          addr_q;
   logic [TEMP_W:0]            cf_q, fc_q;
   logic [CH_W-1:0]            out_ch_q;
   logic                       out_unit_q;
   logic [TEMP_W-1:0]          data_q;
   logic                       oor_q;
   logic [TEMP_W:0]            res_d;
   logic                       advance;
   logic                       out_hs;

   assign advance = !vld_pipe_q[2] || bus.out_ready;
   assign out_hs  = vld_pipe_q[2] && bus.out_ready;
   assign res_d   = unit_pipe_q[1] ? cf_q : fc_q;

   // A stall freezes the whole pipe, ROM reads included, so nothing drops or repeats.
   always_ff @(posedge gclk_i or negedge grst_n_i) begin
      if (!grst_n_i) begin
         vld_pipe_q  <= '0;
         ch_pipe_q   <= '0;
         unit_pipe_q <= '0;
         addr_q      <= '0;
         cf_q        <= '0;
         fc_q        <= '0;
         out_ch_q    <= '0;
         out_unit_q  <= 1'b0;
         data_q      <= '0;
         oor_q       <= 1'b0;
      end else if (advance) begin
         vld_pipe_q      <= {vld_pipe_q[1:0], bus.in_valid};
         ch_pipe_q       <= {ch_pipe_q[0], bus.in_ch};
         unit_pipe_q     <= {unit_pipe_q[0], bus.unit};
         addr_q          <= bus.temperature;
         cf_q            <= cf_rom[addr_q];
         fc_q            <= fc_rom[addr_q];
         out_ch_q        <= ch_pipe_q[1];
         out_unit_q      <= unit_pipe_q[1];
         {oor_q, data_q} <= res_d;
      end
   end

   assign bus.in_ready  = advance;
   assign bus.out_valid = vld_pipe_q[2];
   assign bus.out_ch    = out_ch_q;
   assign bus.out_unit  = out_unit_q;
   assign bus.data      = data_q;
   assign bus.oor       = oor_q;

   for (genvar k = 0; k < CH; k++) begin : g_lane
      temp_conv_lane #(.TEMP_W(TEMP_W)) u_lane (
         .gclk_i   (gclk_i),
         .grst_n_i (grst_n_i),
         .en_i     (out_hs && (out_ch_q == CH_W'(k))),
         .d_i      (data_q),
         .q_o      (last_data_o[k])
      );
   end
endmodule

// File: tb/tb_temp_conv_pipe.sv
// Self-checking bench for temp_conv_pipe: directed sweeps plus randomized
// backpressure against a scoreboard built from the conversion formulas.
module tb_temp_conv_pipe;
   localparam int TEMP_W = 8;
   localparam int CH     = 4;
   localparam int CH_W   = 2;

   logic gclk   = 1'b0;
   logic grst_n = 1'b0;
   logic [CH-1:0][TEMP_W-1:0] last_data;

   temp_conv_pipe_if #(.TEMP_W(TEMP_W), .CH_W(CH_W)) bus ();

   temp_conv_pipe #(.TEMP_W(TEMP_W), .CH(CH), .C_MAX(100), .F_MAX(212)) dut (
      .gclk_i      (gclk),
      .grst_n_i    (grst_n),
      .bus         (bus.slave),
      .last_data_o (last_data)
   );

   always #5 gclk = ~gclk;

   typedef struct {
      int ch;
      int unit;
      int data;
      int oor;
      int acc;
   } exp_t;

   exp_t        sb[$];
   int          mlast[CH];
   int          cyc, checks, errors;
   bit          strict, rand_rdy, accepted, hold_prev;
   logic [31:0] prev_out;

   function automatic exp_t model(input int ch, input int u, input int t);
      exp_t e;
      e.ch = ch; e.unit = u; e.acc = 0;
      if (u == 1) begin
         if (t > 100) begin e.data = 212; e.oor = 1; end
         else begin e.data = (18*t + 5) / 10 + 32; e.oor = 0; end
      end else begin
         if (t < 32)       begin e.data = 0;   e.oor = 1; end
         else if (t > 212) begin e.data = 100; e.oor = 1; end
         else begin e.data = (10*(t - 32) + 9) / 18; e.oor = 0; end
      end
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] out_bits();
      return {19'd0, bus.out_valid, bus.out_ch, bus.out_unit, bus.oor, bus.data};
   endfunction

   function automatic logic [31:0] mlast_bits();
      logic [CH-1:0][TEMP_W-1:0] v;
      for (int k = 0; k < CH; k++) v[k] = TEMP_W'(mlast[k]);
      return 32'(v);
   endfunction

   // One clock: entered just after a negedge with inputs set, leaves at the next negedge.
   task automatic cycle();
      exp_t e;
      if (rand_rdy) bus.out_ready = ($urandom_range(0, 9) >= 3);
      #1;
      accepted = 1'b0;
      chk("in_ready", 32'(bus.in_ready), 32'(!(bus.out_valid && !bus.out_ready)));
      if (hold_prev) chk("hold", out_bits(), prev_out);
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) chk("spurious_out", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("data", 32'(bus.data), 32'(e.data));
            chk("oor", 32'(bus.oor), 32'(e.oor));
            chk("out_ch", 32'(bus.out_ch), 32'(e.ch));
            chk("out_unit", 32'(bus.out_unit), 32'(e.unit));
            if (strict) chk("latency", 32'(cyc - e.acc), 32'd3);
            mlast[e.ch] = e.data;
         end
      end
      if (bus.in_valid && bus.in_ready) begin
         e = model(int'(bus.in_ch), int'(bus.unit), int'(bus.temperature));
         e.acc = cyc;
         sb.push_back(e);
         accepted = 1'b1;
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_out  = out_bits();
      @(posedge gclk);
      cyc++;
      #1;
      chk("last_data", 32'(last_data), mlast_bits());
      @(negedge gclk);
   endtask

   task automatic send(input int ch, input int u, input int t);
      bus.in_valid    = 1'b1;
      bus.in_ch       = CH_W'(ch);
      bus.unit        = u[0];
      bus.temperature = TEMP_W'(t);
      for (int i = 0; i < 50; i++) begin
         cycle();
         if (accepted) break;
      end
      if (!accepted) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 200 && sb.size() > 0; i++) cycle();
      chk("drain_empty", 32'(sb.size()), 32'd0);
      cycle();
   endtask

   initial begin
      cyc = 0; checks = 0; errors = 0;
      strict = 1'b1; rand_rdy = 1'b0; hold_prev = 1'b0; prev_out = '0;
      for (int k = 0; k < CH; k++) mlast[k] = 0;
      bus.in_valid = 1'b0; bus.in_ch = '0; bus.unit = 1'b0;
      bus.temperature = '0; bus.out_ready = 1'b1;

      // reset state
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_fields", out_bits(), 32'd0);
      chk("rst_last_data", 32'(last_data), 32'd0);
      @(negedge gclk); @(negedge gclk);
      grst_n = 1'b1;
      cycle();

      // C->F sweep, back-to-back
      for (int t = 0; t <= 100; t++) send(t % CH, 1, t);
      drain();
      // F->C sweep
      for (int t = 0; t <= 212; t++) send(t % CH, 0, t);
      drain();
      // saturation corners
      send(1, 1, 101);
      send(2, 1, 255);
      send(3, 0, 213);
      drain();

      // randomized backpressure, alternating unit
      strict = 1'b0; rand_rdy = 1'b1;
      for (int i = 0; i < 300; i++)
         send(int'($urandom_range(0, CH-1)), i % 2, int'($urandom_range(0, 255)));
      rand_rdy = 1'b0; bus.out_ready = 1'b1;
      drain();
      strict = 1'b1;

      // reset with two requests in flight
      send(1, 1, 50);
      send(2, 0, 100);
      bus.in_valid = 1'b0;
      grst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_last_data", 32'(last_data), 32'd0);
      sb.delete();
      for (int k = 0; k < CH; k++) mlast[k] = 0;
      hold_prev = 1'b0;
      @(negedge gclk); @(negedge gclk);
      grst_n = 1'b1;
      for (int i = 0; i < 4; i++) cycle();

      // per-channel result registers
      send(0, 1, 25);
      drain();
      chk("ch0_first", 32'(last_data[0]), 32'd77);
      send(3, 0, 212);
      send(0, 1, 0);
      drain();
      chk("final_ch0", 32'(last_data[0]), 32'd32);
      chk("final_ch1", 32'(last_data[1]), 32'd0);
      chk("final_ch2", 32'(last_data[2]), 32'd0);
      chk("final_ch3", 32'(last_data[3]), 32'd100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
